datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Multi-cycle instruction sequencer that owns the program counter and instruction register for the RV32IM core.
- Replaces the "reset the ALU whenever PC changes" scheme with explicit handshakes to instruction memory, the multi-cycle ALU, and data memory.
- Adds configurable wait states, a debug halt, a retired-instruction counter, and a watchdog trap on stalled handshakes.
- Sits between ProgramCounter/InstructionMemory and ControlLogic/ALU/DataMemory/RegisterFile in the datapath.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 64, maximum wait cycles for any handshake before trap (≥2).
- RETIRE_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ifetch_req  out  1  instruction fetch request, held until ifetch_valid
- ifetch_addr  out  XLEN  fetch address (= pc)
- ifetch_valid  in  1  fetch data valid
- ifetch_data  in  32  fetched instruction
- ins  out  32  instruction register
- ctl_mem  in  1  decoded instruction is load/store
- ctl_regwen  in  1  decoded instruction writes rd
- ctl_redirect  in  1  branch taken / jump
- redirect_pc  in  XLEN  target PC when ctl_redirect
- alu_start  out  1  one-cycle ALU start pulse
- alu_ready  in  1  ALU result valid
- dmem_req  out  1  data memory request, held until dmem_ack
- dmem_ack  in  1  data memory access complete
- rf_we  out  1  register-file write strobe, one cycle
- pc  out  XLEN  current PC
- pc_plus4  out  XLEN  pc + 4
- halt_req  in  1  debug halt request
- halted  out  1  sequencer is in HALT
- trap  out  1  sticky error flag
- trap_cause  out  3  0 none, 1 fetch timeout, 2 ALU timeout, 3 mem timeout, 4 misaligned redirect
- retired  out  RETIRE_WIDTH  count of committed instructions

Behaviour:
- Reset values:
  - state IDLE, pc=RESET_PC, ins=32'h0000_0013 (NOP).
  - ifetch_req, alu_start, dmem_req, rf_we, halted, trap all 0; trap_cause=0; retired=0.
- Outputs are Moore functions of state, except ins, pc, retired, trap and trap_cause, which are registers.
- pc_plus4 is combinational pc+4 and wraps modulo 2^XLEN.
- States and transitions:
  - IDLE: next state FETCH unless halt_req, in which case HALT.
  - FETCH: ifetch_req=1. On ifetch_valid, latch ins←ifetch_data and go to EXEC.
  - EXEC: alu_start=1 only on the first cycle in EXEC. alu_ready is ignored on that cycle and sampled from the second cycle on. On alu_ready, go to MEM if ctl_mem, otherwise WB.
  - MEM: dmem_req=1. On dmem_ack, go to WB.
  - WB:
    - rf_we=ctl_regwen and retired++ (wraps).
    - pc←ctl_redirect ? redirect_pc : pc_plus4.
    - If ctl_redirect and redirect_pc[1:0]≠0: pc is not updated, no retire, rf_we=0, go to TRAP with cause 4.
    - Otherwise go to HALT if halt_req, else FETCH.
  - HALT: halted=1. Return to FETCH on the first cycle halt_req=0.
  - TRAP: all requests 0; trap=1. Remains in TRAP until rst.
- Minimum latency with zero-wait responders: 4 cycles for a non-memory instruction (FETCH 1, EXEC 2, WB 1) and 5 cycles for a memory instruction.
- Watchdog:
  - The counter clears on every state entry and counts each cycle spent in FETCH, EXEC or MEM without the completing handshake.
  - When the count reaches TIMEOUT_CYCLES-1 with no handshake, the next state is TRAP and trap_cause is set (1, 2 or 3).
  - A handshake arriving in the same cycle the timeout would fire wins: no trap.
- halt_req is sampled only in IDLE, WB and HALT. It never interrupts an in-flight instruction.
- ctl_* and redirect_pc are sampled in the state that uses them; the decoder is combinational from ins.
- rst mid-instruction: at the next edge, abandon all handshakes and return to reset values. Requests drop in the cycle after the reset edge; responders must tolerate this.

Decomposition:
- Shared package core_seq_pkg:
  - state enum: IDLE, FETCH, EXEC, MEM, WB, HALT, TRAP.
  - trap_cause enum (3 bits).
  - NOP_INSN constant 32'h0000_0013.
- One sub-module: handshake_watchdog, parametrised by TIMEOUT_CYCLES. Inputs: clear, count_en, done. Output: expired.

Test Plan:
- Zero-wait run, RESET_PC=0, four ADDI instructions, no redirects → pc 0,4,8,12,16 at 4-cycle intervals; retired=4 after 16 cycles; rf_we pulses 4 times.
- Load with dmem_ack delayed 5 cycles → dmem_req held exactly 6 cycles, one rf_we, total 10 cycles for the instruction.
- JAL with redirect_pc=0x40 → next ifetch_addr=0x40. Redirect to 0x42 → trap=1, trap_cause=4, pc remains at the JAL address, retired unchanged.
- ALU never returns alu_ready with TIMEOUT_CYCLES=8 → TRAP entered with cause 2. Separately, alu_ready arriving on the expiring cycle → no trap.
- halt_req asserted mid-EXEC → the instruction completes, halted=1 after WB, no fetch while halted; deassert → fetch resumes at pc+4.
- rst asserted during MEM → the next cycle has dmem_req=0, pc=RESET_PC, retired=0, ins=0x00000013, state IDLE, then FETCH.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types for the instruction sequencer: FSM states, trap causes, reset instruction.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_TRAP  = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    TC_NONE     = 3'd0,
    TC_FETCH    = 3'd1,
    TC_ALU      = 3'd2,
    TC_MEM      = 3'd3,
    TC_MISALIGN = 3'd4
  } trap_cause_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/handshake_watchdog.sv
// Counts cycles spent waiting on a handshake; flags expiry on the last allowed cycle.
module handshake_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  input  logic done,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A handshake on the final cycle beats the timeout.
  assign expired = count_en && !done && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !done && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer owning PC and IR; handshakes with imem, ALU and dmem,
// with debug halt, retire counter and watchdog trap.
module datapath_sequencer
  import core_seq_pkg::*;
#(
  parameter int               XLEN           = 32,
  parameter logic [XLEN-1:0]  RESET_PC       = '0,
  parameter int               TIMEOUT_CYCLES = 64,
  parameter int               RETIRE_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ifetch_req,
  output logic [XLEN-1:0]         ifetch_addr,
  input  logic                    ifetch_valid,
  input  logic [31:0]             ifetch_data,
  output logic [31:0]             ins,
  input  logic                    ctl_mem,
  input  logic                    ctl_regwen,
  input  logic                    ctl_redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    alu_start,
  input  logic                    alu_ready,
  output logic                    dmem_req,
  input  logic                    dmem_ack,
  output logic                    rf_we,
  output logic [XLEN-1:0]         pc,
  output logic [XLEN-1:0]         pc_plus4,
  input  logic                    halt_req,
  output logic                    halted,
  output logic                    trap,
  output logic [2:0]              trap_cause,
  output logic [RETIRE_WIDTH-1:0] retired
);

  seq_state_t              state_q, state_d;
  logic [XLEN-1:0]         pc_q, pc_d;
  logic [31:0]             ins_q, ins_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic                    trap_q, trap_d;
  trap_cause_t             cause_q, cause_d;
  logic                    exec_first_q;
  logic                    wd_done, wd_count_en, wd_expired;
  logic                    misaligned;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign ifetch_addr = pc_q;
  assign ins         = ins_q;
  assign retired     = retired_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign misaligned  = ctl_redirect && (redirect_pc[1:0] != 2'b00);

  assign wd_count_en = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MEM);
  // alu_ready on the start cycle belongs to nothing and must not count as done.
  assign wd_done = ((state_q == ST_FETCH) && ifetch_valid) ||
                   ((state_q == ST_EXEC) && alu_ready && !exec_first_q) ||
                   ((state_q == ST_MEM) && dmem_ack);

  handshake_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d != state_q),
    .count_en (wd_count_en),
    .done     (wd_done),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    retired_d  = retired_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    ifetch_req = 1'b0;
    alu_start  = 1'b0;
    dmem_req   = 1'b0;
    rf_we      = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = halt_req ? ST_HALT : ST_FETCH;
      ST_FETCH: begin
        ifetch_req = 1'b1;
        if (ifetch_valid) begin
          ins_d   = ifetch_data;
          state_d = ST_EXEC;
        end else if (wd_expired) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_FETCH;
        end
      end
      ST_EXEC: begin
        alu_start = exec_first_q;
        if (alu_ready && !exec_first_q) begin
          state_d = ctl_mem ? ST_MEM : ST_WB;
        end else if (wd_expired) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_ALU;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (wd_expired) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_MEM;
        end
      end
      ST_WB: begin
        if (misaligned) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_MISALIGN;
        end else begin
          rf_we     = ctl_regwen;
          retired_d = retired_q + RETIRE_WIDTH'(1);
          pc_d      = ctl_redirect ? redirect_pc : pc_plus4;
          state_d   = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_d = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ins_q        <= NOP_INSN;
      retired_q    <= '0;
      trap_q       <= 1'b0;
      cause_q      <= TC_NONE;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ins_q        <= ins_d;
      retired_q    <= retired_d;
      trap_q       <= trap_d;
      cause_q      <= cause_d;
      exec_first_q <= (state_d == ST_EXEC) && (state_q != ST_EXEC);
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with behavioural imem/ALU/dmem responders.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_req, ifetch_valid;
  logic [31:0] ifetch_addr, ifetch_data, ins;
  logic        ctl_mem, ctl_regwen, ctl_redirect;
  logic [31:0] redirect_pc;
  logic        alu_start, alu_ready, dmem_req, dmem_ack, rf_we;
  logic [31:0] pc, pc_plus4, retired;
  logic        halt_req = 1'b0;
  logic        halted, trap;
  logic [2:0]  trap_cause;

  int errors = 0;
  int checks = 0;
  int mem_wait = 0;
  int alu_mode = 0;
  int acnt = 0;
  int mcnt = 0;
  int we_cnt = 0;
  int dreq_cnt = 0;
  int we0, dq0;
  logic [31:0] imem [0:31];

  always #5 clk = ~clk;

  datapath_sequencer #(
    .XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(8), .RETIRE_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
    .ifetch_valid(ifetch_valid), .ifetch_data(ifetch_data), .ins(ins),
    .ctl_mem(ctl_mem), .ctl_regwen(ctl_regwen), .ctl_redirect(ctl_redirect),
    .redirect_pc(redirect_pc), .alu_start(alu_start), .alu_ready(alu_ready),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .pc(pc), .pc_plus4(pc_plus4), .halt_req(halt_req), .halted(halted),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  // Responders and a minimal combinational decoder.
  assign ifetch_valid = ifetch_req;
  assign ifetch_data  = imem[ifetch_addr[6:2]];
  assign ctl_mem      = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
  assign ctl_regwen   = (ins[6:0] == 7'h13) || (ins[6:0] == 7'h03) || (ins[6:0] == 7'h6F);
  assign ctl_redirect = (ins[6:0] == 7'h6F);
  assign redirect_pc  = (pc == 32'd20) ? 32'h40 : 32'h42;
  assign alu_ready    = (alu_mode == 0) || ((alu_mode == 2) && !alu_start && (acnt == 7));
  assign dmem_ack     = dmem_req && (mcnt >= mem_wait);

  always @(posedge clk) begin
    acnt     <= alu_start ? 1 : acnt + 1;
    mcnt     <= dmem_req ? mcnt + 1 : 0;
    we_cnt   <= rf_we ? we_cnt + 1 : we_cnt;
    dreq_cnt <= dmem_req ? dreq_cnt + 1 : dreq_cnt;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0013;
    imem[0]  = 32'h0010_8093;
    imem[1]  = 32'h0020_8093;
    imem[2]  = 32'h0030_8093;
    imem[3]  = 32'h0040_8093;
    imem[4]  = 32'h0000_2103;
    imem[5]  = 32'h0200_00EF;
    imem[16] = 32'h0000_00EF;

    // Reset state
    tick(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ins", ins, 32'h13);
    chk("rst_req", {ifetch_req, alu_start, dmem_req, rf_we, halted, trap}, 32'h0);
    chk("rst_cause", {29'h0, trap_cause}, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    rst = 1'b0;

    // Four zero-wait ADDIs
    tick(1);
    chk("f0_req", {31'h0, ifetch_req}, 32'h1);
    chk("f0_addr", ifetch_addr, 32'h0);
    tick(1);
    chk("e0_ins", ins, 32'h0010_8093);
    chk("e0_start", {31'h0, alu_start}, 32'h1);
    tick(1);
    chk("e0_start2", {31'h0, alu_start}, 32'h0);
    tick(1);
    chk("wb0_rfwe", {31'h0, rf_we}, 32'h1);
    tick(1);
    chk("f1_addr", ifetch_addr, 32'h4);
    tick(4);
    chk("f2_addr", ifetch_addr, 32'h8);
    tick(4);
    chk("f3_addr", ifetch_addr, 32'hC);
    tick(4);
    chk("f4_pc", pc, 32'h10);
    chk("f4_retired", retired, 32'd4);
    chk("f4_rfwe_cnt", we_cnt, 32'd4);

    // Load with five-cycle dmem delay
    mem_wait = 5;
    we0 = we_cnt;
    dq0 = dreq_cnt;
    tick(3);
    chk("ld_memreq", {31'h0, dmem_req}, 32'h1);
    tick(6);
    chk("ld_wb_req", {31'h0, dmem_req}, 32'h0);
    chk("ld_wb_rfwe", {31'h0, rf_we}, 32'h1);
    tick(1);
    chk("ld_pc", pc, 32'd20);
    chk("ld_retired", retired, 32'd5);
    chk("ld_req_cycles", dreq_cnt - dq0, 32'd6);
    chk("ld_rfwe_cnt", we_cnt - we0, 32'd1);

    // JAL to 0x40, then JAL to misaligned 0x42
    tick(4);
    chk("jal_addr", ifetch_addr, 32'h40);
    chk("jal_retired", retired, 32'd6);
    tick(3);
    chk("mis_wb_rfwe", {31'h0, rf_we}, 32'h0);
    tick(1);
    chk("mis_trap", {31'h0, trap}, 32'h1);
    chk("mis_cause", {29'h0, trap_cause}, 32'd4);
    chk("mis_pc", pc, 32'h40);
    chk("mis_retired", retired, 32'd6);
    tick(5);
    chk("mis_sticky", {31'h0, trap}, 32'h1);
    chk("mis_noreq", {29'h0, ifetch_req, dmem_req, alu_start}, 32'h0);

    // Reset in the middle of MEM
    mem_wait = 100;
    do_reset();
    tick(20);
    chk("mr_inmem", {31'h0, dmem_req}, 32'h1);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("mr_dreq", {31'h0, dmem_req}, 32'h0);
    chk("mr_pc", pc, 32'h0);
    chk("mr_retired", retired, 32'h0);
    chk("mr_ins", ins, 32'h13);
    chk("mr_idle", {31'h0, ifetch_req}, 32'h0);
    rst = 1'b0;
    tick(1);
    chk("mr_fetch", {31'h0, ifetch_req}, 32'h1);
    mem_wait = 0;

    // ALU never ready: trap after eight EXEC cycles
    alu_mode = 1;
    do_reset();
    tick(9);
    chk("at_notyet", {31'h0, trap}, 32'h0);
    tick(1);
    chk("at_trap", {31'h0, trap}, 32'h1);
    chk("at_cause", {29'h0, trap_cause}, 32'd2);

    // ALU ready on the expiring cycle wins
    alu_mode = 2;
    do_reset();
    tick(9);
    chk("ae_ready", {31'h0, alu_ready}, 32'h1);
    tick(1);
    chk("ae_notrap", {31'h0, trap}, 32'h0);
    chk("ae_wb", {31'h0, rf_we}, 32'h1);
    tick(1);
    chk("ae_retired", retired, 32'd1);
    alu_mode = 0;

    // Halt requested mid-EXEC
    do_reset();
    tick(2);
    halt_req = 1'b1;
    tick(2);
    chk("h_wb", {30'h0, halted, rf_we}, 32'h1);
    tick(1);
    chk("h_halted", {31'h0, halted}, 32'h1);
    chk("h_pc", pc, 32'h4);
    tick(3);
    chk("h_nofetch", {30'h0, halted, ifetch_req}, 32'h2);
    halt_req = 1'b0;
    tick(1);
    chk("h_resume", {30'h0, halted, ifetch_req}, 32'h1);
    chk("h_addr", ifetch_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
